aes_128_key_sched_ctrl: RTL and testbench

Iterative AES-128 key-expansion controller. It captures a 128-bit cipher key on `start` and issues the 11 round keys (round 0 = cipher key, rounds 1..10 expanded) one per handshake. Expansion uses a single shared `g_function` instance (RotWord+SubWord, 4 S-boxes) plus on-the-fly Rcon. It sits between key load and the round datapath of the AES-128 encryption core, replacing a fully unrolled 10-stage key schedule.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/g_function.sv | 20 ++
 rtl/sbox.sv | 51 +++++
 rtl/aes_128_key_sched_ctrl.sv | 110 +++++++++++
 tb/tb_aes_128_key_sched_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule controller.
//   AES128_NR   : last round index for AES-128
//   RCON_INIT   : first Rcon value
//   RCON_POLY   : GF(2^8) reduction constant applied by xtime
//   ks_state_t  : key-schedule controller states
//   xtime       : multiply-by-x in GF(2^8)
package aes_pkg;

    localparam int         AES128_NR = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/g_function.sv
// Key-schedule g function: RotWord followed by SubWord (Rcon applied by caller).
//   w : input word
//   g : {S(w[23:16]), S(w[15:8]), S(w[7:0]), S(w[31:24])}
module g_function (
    input  logic [31:0] w,
    output logic [31:0] g
);

    logic [31:0] rot;

    assign rot = {w[23:0], w[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .a (rot[8*i +: 8]),
            .s (g[8*i +: 8])
        );
    end

endmodule

// File: rtl/sbox.sv
// AES forward S-box.
//   a : input byte
//   s : substituted byte
// Computed as the GF(2^8) multiplicative inverse (a^254, with 0 -> 0)
// followed by the AES affine transform.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        s   = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

endmodule

// File: rtl/aes_128_key_sched_ctrl.sv
// Iterative AES-128 key-expansion controller.
// Captures the cipher key on start and issues round keys 0..NUM_ROUNDS one per
// rk_valid/rk_ready handshake, expanding one round per accepted key.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin expansion of key_in (honoured only when idle)
//   key_in     : cipher key, [127:96] = w0
//   rk_ready   : consumer accepts round_key
//   rk_valid   : round_key/round_idx valid
//   round_key  : current round key
//   round_idx  : index of round_key
//   busy       : expansion in progress
//   done       : one-cycle pulse after the last key is accepted
module aes_128_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    if (NUM_ROUNDS != AES128_NR) begin : g_bad_num_rounds
        $error("aes_128_key_sched_ctrl: NUM_ROUNDS must be %0d", AES128_NR);
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_t    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;

    logic [31:0]  g_out;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;

    g_function u_g_function (
        .w (key_q[31:0]),
        .g (g_out)
    );

    assign t  = g_out ^ {rcon_q, 24'h0};
    assign n0 = key_q[127:96] ^ t;
    assign n1 = key_q[95:64]  ^ n0;
    assign n2 = key_q[63:32]  ^ n1;
    assign n3 = key_q[31:0]   ^ n2;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = '0;
                    rcon_d  = RCON_INIT;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        key_d  = {n0, n1, n2, n3};
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
        end
    end

    assign rk_valid  = (state_q == ISSUE);
    assign busy      = (state_q == ISSUE);
    assign done      = (state_q == DONE);
    assign round_key = key_q;
    assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_128_key_sched_ctrl.sv
module tb_aes_128_key_sched_ctrl;

    localparam int NR = 10;

    localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_ZERO1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K_ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int vectors = 0;
    int errs    = 0;

    logic [127:0] exp_rk [NR+1];
    logic [127:0] obs_rk [NR+1];

    always #5 clk = ~clk;

    aes_128_key_sched_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // FIPS-197 word-wise key expansion
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    task automatic build(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {RCON[i/4-1], 24'h0};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, rk_valid, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_key"},   round_key, 0);
        chk({tag, "_idx"},   round_idx, 0);
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_done",  done, 0);
        chk("idle_valid", rk_valid, 0);
        chk("idle_busy",  busy, 0);
    endtask

    // Called at a negedge while the DUT is idle; start is accepted at the next edge.
    task automatic start_exp(input logic [127:0] key, input bit hold);
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        if (!hold) begin
            start  = 1'b0;
            key_in = rand128();
        end
    endtask

    // Entered at the negedge of the first presentation cycle.
    task automatic watch(input logic [127:0] key, input int stall_pct, input int poke_at,
                         input int rst_at, output bit aborted);
        int n, cycles, stalls;
        bit poked;
        build(key);
        n = 0; cycles = 0; stalls = 0; poked = 0; aborted = 0;
        while (n <= NR && cycles < 400) begin
            chk("valid", rk_valid, 1);
            chk("busy", busy, 1);
            chk("done_low", done, 0);
            chk("idx", round_idx, n);
            chk("key", round_key, exp_rk[n]);
            obs_rk[n] = round_key;
            if (n == rst_at) begin
                rst = 1'b1;
                rk_ready = 1'($urandom_range(1));
                @(negedge clk);
                rst = 1'b0;
                check_reset_vals("mid_rst");
                aborted = 1;
                return;
            end
            if (n == poke_at && !poked) begin
                start  = 1'b1;
                key_in = ~key;
                poked  = 1;
            end else if (poked) begin
                start = 1'b0;
            end
            rk_ready = ($urandom_range(99) >= stall_pct);
            if (!rk_ready) stalls++;
            @(negedge clk);
            cycles++;
            if (rk_ready) n++;
        end
        if (n <= NR) chk("timeout_idx", n, NR + 1);
        chk("cycles", cycles, 11 + stalls);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("valid_in_done", rk_valid, 0);
        rk_ready = 1'b0;
    endtask

    initial begin
        bit ab;
        logic [127:0] k, k2;
        rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 key, consumer always ready
        start_exp(K_FIPS, 0);
        watch(K_FIPS, 0, -1, -1, ab);
        chk("fips_idx0", obs_rk[0], K_FIPS);
        chk("fips_idx1", obs_rk[1], K_FIPS1);
        chk("fips_idx10", obs_rk[10], K_FIPS10);
        idle_check();

        // same key with random stalls
        start_exp(K_FIPS, 0);
        watch(K_FIPS, 40, -1, -1, ab);
        chk("stall_idx10", obs_rk[10], K_FIPS10);
        idle_check();

        // all-zero key
        start_exp('0, 0);
        watch('0, 20, -1, -1, ab);
        chk("zero_idx1", obs_rk[1], K_ZERO1);
        chk("zero_idx10", obs_rk[10], K_ZERO10);
        idle_check();

        // start with a different key mid-run is ignored
        k = rand128();
        start_exp(k, 0);
        watch(k, 30, 4, -1, ab);
        idle_check();

        // reset at idx 6, then a fresh expansion
        k = rand128();
        start_exp(k, 0);
        watch(k, 25, -1, 6, ab);
        chk("rst_aborted", 128'(ab), 1);
        k = rand128();
        start_exp(k, 0);
        watch(k, 25, -1, -1, ab);
        idle_check();

        // start held high: second run begins after the idle cycle following done
        k  = rand128();
        k2 = rand128();
        start_exp(k, 1);
        key_in = k2;
        watch(k, 20, -1, -1, ab);
        idle_check();
        @(negedge clk);
        start = 1'b0;
        watch(k2, 20, -1, -1, ab);
        chk("b2b_idx0", obs_rk[0], k2);
        idle_check();

        // random keys
        for (int i = 0; i < 4; i++) begin
            k = rand128();
            start_exp(k, 0);
            watch(k, $urandom_range(50), -1, -1, ab);
            idle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
